// File: rtl/hex_display_scheduler.sv
// Round-robin time-sharing of one 7-segment decoder between N_REQ requesters.
// Each grant lasts DWELL cycles or until its requester drops, and all outputs are registered.
module hex_display_scheduler #(
   parameter int N_REQ = 4,
   parameter int DWELL = 25000000,
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] nibble_in,
   output logic [3:0]         nibble_out,
   output logic               blank,
   output logic [N_REQ-1:0]   grant,
   output logic [IW-1:0]      grant_idx,
   output logic               slot_tick,
   output logic               dbg_state
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [IW-1:0]     last, last_nx;
   logic [IW-1:0]     grant_idx_nx;
   logic [N_REQ-1:0]  grant_nx;
   logic [3:0]        nibble_nx;
   logic              blank_nx;
   logic              tick_nx;

   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [3:0]        nib_win;
   logic [3:0]        nib_held;
   logic              rearb;
   logic              release_now;

   // Search last+1, last+2, ... wrapping, so the previous winner is checked last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         logic [IW-1:0] cand;
         cand = IW'((int'(last) + k) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      nib_win  = '0;
      nib_held = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IW'(i) == win_idx)   nib_win  = nibble_in[4*i +: 4];
         if (IW'(i) == grant_idx) nib_held = nibble_in[4*i +: 4];
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      last_nx      = last;
      grant_idx_nx = grant_idx;
      blank_nx     = blank;
      nibble_nx    = nibble_out;
      tick_nx      = 1'b0;
      rearb        = 1'b0;
      release_now  = 1'b0;

      case (state)
         IDLE: rearb = 1'b1;
         HOLD: begin
            release_now = (cnt == '0) || !req[grant_idx];
            if (release_now) begin
               rearb = 1'b1;
            end else begin
               cnt_nx    = cnt - CW'(1);
               nibble_nx = nib_held;
            end
         end
         default: state_nx = IDLE;
      endcase

      // A release and a new grant share one edge, so there is never an idle gap.
      if (rearb) begin
         if (win_found) begin
            state_nx     = HOLD;
            cnt_nx       = CW'(DWELL - 1);
            last_nx      = win_idx;
            grant_idx_nx = win_idx;
            blank_nx     = 1'b0;
            tick_nx      = 1'b1;
            nibble_nx    = nib_win;
         end else begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            grant_idx_nx = '0;
            blank_nx     = 1'b1;
         end
      end

      grant_nx = '0;
      if (!blank_nx) grant_nx[grant_idx_nx] = 1'b1;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         last       <= IW'(N_REQ - 1);
         grant_idx  <= '0;
         grant      <= '0;
         blank      <= 1'b1;
         nibble_out <= '0;
         slot_tick  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         last       <= last_nx;
         grant_idx  <= grant_idx_nx;
         grant      <= grant_nx;
         blank      <= blank_nx;
         nibble_out <= nibble_nx;
         slot_tick  <= tick_nx;
      end
   end

   assign dbg_state = (state == HOLD);

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with DWELL=4, N_REQ=4; a monitor checks every
// slot_tick against a queue of expected grants while the driver checks held/blank states.
module tb_hex_display_scheduler;

   logic        Clock;
   logic        Resetn;
   logic [3:0]  req;
   logic [15:0] nibble_in;
   logic [3:0]  nibble_out;
   logic        blank;
   logic [3:0]  grant;
   logic [1:0]  grant_idx;
   logic        slot_tick;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick_cyc = 0;

   // Entry layout: {gap[7:0], grant[3:0], idx[1:0], nibble[3:0]}; gap 0 = not checked.
   logic [17:0] exp_q[$];

   hex_display_scheduler #(.N_REQ(4), .DWELL(4)) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .req(req),
      .nibble_in(nibble_in),
      .nibble_out(nibble_out),
      .blank(blank),
      .grant(grant),
      .grant_idx(grant_idx),
      .slot_tick(slot_tick),
      .dbg_state(dbg_state)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc = cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_tick(input logic [3:0] g, input logic [1:0] idx,
                              input logic [3:0] nib, input logic [7:0] gap);
      exp_q.push_back({gap, g, idx, nib});
   endtask

   // Monitor: every slot_tick is one scheduler output event.
   always begin
      logic [17:0] e;
      @(posedge Clock);
      #1;
      if (slot_tick === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick actual=grant %b expected=no tick (t=%0t)", grant, $time);
         end else begin
            e = exp_q.pop_front();
            check("tick_grant", 32'(grant), 32'(e[9:6]));
            check("tick_idx", 32'(grant_idx), 32'(e[5:4]));
            check("tick_nibble", 32'(nibble_out), 32'(e[3:0]));
            check("tick_blank", 32'(blank), 32'd0);
            if (e[17:10] != 8'd0)
               check("tick_gap", 32'(cyc - last_tick_cyc), 32'(e[17:10]));
         end
         last_tick_cyc = cyc;
      end
   end

   initial begin
      Resetn    = 1'b0;
      req       = 4'b1111;
      nibble_in = 16'hFEDC;
      repeat (3) @(negedge Clock);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_idx", 32'(grant_idx), 32'd0);
      check("rst_nibble", 32'(nibble_out), 32'd0);
      check("rst_tick", 32'(slot_tick), 32'd0);

      req    = 4'b0000;
      Resetn = 1'b1;
      @(negedge Clock);
      check("idle_blank", 32'(blank), 32'd1);

      // Single requester: re-granted every 4 cycles with no gap.
      nibble_in = 16'h1A23;
      req       = 4'b0100;
      expect_tick(4'b0100, 2'd2, 4'hA, 8'd0);
      repeat (3) expect_tick(4'b0100, 2'd2, 4'hA, 8'd4);
      for (int i = 0; i < 14; i++) begin
         @(negedge Clock);
         check("single_grant_held", 32'(grant), 32'b0100);
      end
      req = 4'b0000;
      @(negedge Clock);
      check("release_blank", 32'(blank), 32'd1);
      check("release_grant", 32'(grant), 32'd0);
      check("release_idx", 32'(grant_idx), 32'd0);
      check("release_nibble_held", 32'(nibble_out), 32'hA);

      Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;

      // All requesting: strict rotation from index 0, 4 cycles each.
      nibble_in = 16'h4321;
      req       = 4'b1111;
      expect_tick(4'b0001, 2'd0, 4'h1, 8'd0);
      expect_tick(4'b0010, 2'd1, 4'h2, 8'd4);
      expect_tick(4'b0100, 2'd2, 4'h3, 8'd4);
      expect_tick(4'b1000, 2'd3, 4'h4, 8'd4);
      expect_tick(4'b0001, 2'd0, 4'h1, 8'd4);
      for (int i = 0; i < 17; i++) begin
         @(negedge Clock);
         check("rotate_no_gap", 32'(blank), 32'd0);
      end
      req = 4'b0000;
      @(negedge Clock);
      check("rotate_idle", 32'(blank), 32'd1);

      // Early release: pointer is at 0, so requester 1 wins first, 3 is pending.
      nibble_in = 16'h9050;
      req       = 4'b1010;
      expect_tick(4'b0010, 2'd1, 4'h5, 8'd0);
      @(negedge Clock);
      check("early_first_grant", 32'(grant), 32'b0010);
      @(negedge Clock);
      req = 4'b1000;
      expect_tick(4'b1000, 2'd3, 4'h9, 8'd2);
      expect_tick(4'b1000, 2'd3, 4'h9, 8'd4);
      @(negedge Clock);
      check("early_switch_grant", 32'(grant), 32'b1000);
      check("early_switch_tick", 32'(slot_tick), 32'd1);
      repeat (4) @(negedge Clock);

      // Live nibble tracking during a hold, with one cycle of latency.
      nibble_in = 16'h3050;
      @(negedge Clock);
      check("track_nib3", 32'(nibble_out), 32'h3);
      nibble_in = 16'h7050;
      #1;
      check("track_registered", 32'(nibble_out), 32'h3);
      @(negedge Clock);
      check("track_nib7", 32'(nibble_out), 32'h7);
      check("track_grant_kept", 32'(grant), 32'b1000);
      check("track_no_tick", 32'(slot_tick), 32'd0);

      // Asynchronous reset in the middle of a hold.
      #2;
      Resetn = 1'b0;
      #1;
      check("async_blank", 32'(blank), 32'd1);
      check("async_grant", 32'(grant), 32'd0);
      check("async_idx", 32'(grant_idx), 32'd0);
      check("async_nibble", 32'(nibble_out), 32'd0);
      check("async_tick", 32'(slot_tick), 32'd0);
      @(negedge Clock);
      req    = 4'b1010;
      Resetn = 1'b1;
      expect_tick(4'b0010, 2'd1, 4'h5, 8'd0);
      @(negedge Clock);
      check("post_reset_grant", 32'(grant), 32'b0010);
      req = 4'b0000;
      repeat (3) @(negedge Clock);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
